fir_filter_mac: RTL and testbench
=================================

Name: fir_filter_mac

Overview:
Parametrised, time-multiplexed FIR filter with one multiplier and one accumulator. Coefficients are runtime-programmable, and the input side uses a valid/ready handshake. Output is rounded, shifted and saturated, with a one-cycle valid strobe. It sits on the sample stream between the ADC/decimator front end and downstream DSP, and is the successor to the fixed-coefficient, fixed-width 128-tap filter.

Parameters:
WIDTH, 18, sample width in and out (signed two's complement)
COEF_WIDTH, 18, coefficient width (signed)
TAPS, 128, number of taps; power of two, 4..1024
SHIFT, 8, arithmetic right shift applied to accumulator before output; 0..COEF_WIDTH
ACC_WIDTH, WIDTH+COEF_WIDTH+log2(TAPS), accumulator width; no internal overflow at this width

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous active-high reset
in_data  in  WIDTH  input sample (signed)
in_valid  in  1  in_data valid
in_ready  out  1  block can accept a sample (high only in IDLE)
coef_we  in  1  coefficient write strobe
coef_addr  in  log2(TAPS)  coefficient index k
coef_data  in  COEF_WIDTH  coefficient value (signed)
out_data  out  WIDTH  filtered sample (signed, held until next result)
out_valid  out  1  one-cycle strobe, out_data updated this cycle

Behaviour:
- Storage: delay line of TAPS samples (circular, write pointer wp) and coefficient RAM of TAPS entries.
- y[n] = sat(round(sum over k=0..TAPS-1 of c[k]*x[n-k]) >>> SHIFT).
- States: CLEAR, IDLE, MAC, DRAIN, OUT.
- Reset:
  - rst=1 forces state CLEAR, counter=0, wp=0, accumulator=0, out_data=0, out_valid=0, in_ready=0.
  - Reset has priority over everything, including mid-MAC: the in-flight result is discarded and no out_valid is emitted.
- CLEAR: writes 0 to delay[cnt] and coef[cnt] for cnt=0..TAPS-1, one entry per cycle. Exactly TAPS cycles after rst deasserts, go to IDLE. coef_we is ignored during CLEAR.
- IDLE:
  - in_ready=1.
  - On in_valid=1 (handshake cycle, call it cycle 0): delay[wp] <= in_data, acc <= 0, k <= 0, go to MAC. wp advances by 1 (mod TAPS) at the end of the computation.
  - in_data is sampled only in the handshake cycle.
- MAC, cycles 1..TAPS:
  - Read c[k] and delay[(wp-k) mod TAPS]; register the product p (full WIDTH+COEF_WIDTH, signed).
  - acc += previous p, where valid; k increments each cycle.
  - After k=TAPS-1, go to DRAIN.
- DRAIN, cycle TAPS+1: last product accumulated; go to OUT.
- OUT, cycle TAPS+2:
  - out_data <= saturate_WIDTH((acc + (SHIFT>0 ? 1<<(SHIFT-1) : 0)) >>> SHIFT), i.e. round half up toward +inf.
  - out_valid=1 for this cycle only; wp <= wp+1; go to IDLE.
- Latency and throughput: out_valid is asserted TAPS+2 cycles after the handshake cycle. Maximum throughput is one sample per TAPS+3 cycles.
- Saturation: clamp to [-(2^(WIDTH-1)), 2^(WIDTH-1)-1].
- Coefficient writes:
  - Honoured only in IDLE: coef[coef_addr] <= coef_data, effective for the next accepted sample.
  - Ignored in CLEAR, MAC, DRAIN and OUT.
  - coef_we and in_valid in the same IDLE cycle: the write takes effect before the MAC of that sample starts.
- Backpressure: in_valid held high while in_ready=0 has no effect; the sample is accepted on the first IDLE cycle.
- wp wraps TAPS-1 -> 0; the tap index wraps modulo TAPS.
- out_data holds its last value between strobes.

Test Plan:
Bench setup for all scenarios: WIDTH=18, COEF_WIDTH=18, TAPS=8, SHIFT=8.
- Reset/clear: pulse rst with garbage preloaded -> in_ready low for exactly 8 cycles after rst falls, then high. The first sample with c[0]=256 yields out_data equal to the input; all other taps contribute 0.
- Impulse: c[k]=256*k, feed 1,0,0,... for 10 samples -> out_data sequence 0,1,2,3,4,5,6,7,0,0. Each out_valid occurs exactly 10 cycles after its handshake.
- Rounding: c[0]=128, others 0 -> input 1 gives 1, input -1 gives 0, input 3 gives 2 (384+128=512>>8).
- Saturation: c[0]=131071, others 0 -> input 131071 gives 131071; input -131072 gives -131072.
- Busy rules: coef_we to c[0] during MAC and in_valid held high through the computation -> write ignored (c[0] unchanged in the next result). The next sample is accepted exactly TAPS+3 cycles after the previous handshake.
- Reset mid-MAC: assert rst at cycle 4 after handshake -> no out_valid, out_data=0, CLEAR lasts 8 cycles. The next sample's output reflects a zeroed delay line.

Source files
------------

// File: rtl/fir_filter_mac.sv
// -----------------------------------------------------------------------------
// fir_filter_mac
//   Time-multiplexed FIR filter: one multiplier, one accumulator, TAPS cycles
//   of MAC per accepted sample. Coefficients are written at runtime while the
//   block is idle. The result is rounded half-up, arithmetically shifted right
//   by SHIFT and saturated to WIDTH bits.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_data    input sample (signed)
//   in_valid   in_data valid
//   in_ready   block can accept a sample (only while idle)
//   coef_we    coefficient write strobe (honoured only while idle)
//   coef_addr  coefficient index
//   coef_data  coefficient value (signed)
//   out_data   filtered sample (signed), held between strobes
//   out_valid  one-cycle strobe, out_data updated in this cycle
// -----------------------------------------------------------------------------
module fir_filter_mac #(
    parameter int WIDTH      = 18,
    parameter int COEF_WIDTH = 18,
    parameter int TAPS       = 128,
    parameter int SHIFT      = 8,
    parameter int ACC_WIDTH  = WIDTH + COEF_WIDTH + $clog2(TAPS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       coef_we,
    input  logic [$clog2(TAPS)-1:0]    coef_addr,
    input  logic [COEF_WIDTH-1:0]      coef_data,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid
);

    localparam int ADDR_W = $clog2(TAPS);
    localparam int PROD_W = WIDTH + COEF_WIDTH;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(TAPS - 1);

    // Half an output LSB, expressed at accumulator scale (zero when SHIFT=0).
    localparam logic signed [ACC_WIDTH:0] ROUND_ADD = ((ACC_WIDTH+1)'(1) << SHIFT) >> 1;
    localparam logic signed [ACC_WIDTH:0] SAT_MAX =
        {{(ACC_WIDTH-WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] SAT_MIN =
        {{(ACC_WIDTH-WIDTH+2){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {CLEAR, IDLE, MAC, DRAIN, OUT} state_t;

    state_t state, state_next;

    logic signed [WIDTH-1:0]      delay_mem [TAPS];
    logic signed [COEF_WIDTH-1:0] coef_mem  [TAPS];

    logic [ADDR_W-1:0]            cnt;         // clear index, then tap index k
    logic [ADDR_W-1:0]            wp;          // newest sample lives at delay[wp]
    logic [ADDR_W-1:0]            rd_addr;
    logic signed [PROD_W-1:0]     prod;
    logic                         prod_valid;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic signed [ACC_WIDTH-1:0]  acc_final;
    logic signed [ACC_WIDTH:0]    rounded;
    logic signed [ACC_WIDTH:0]    shifted;
    logic signed [WIDTH-1:0]      sat_value;

    // x[n-k] sits k entries behind the write pointer; ADDR_W-bit wrap gives mod TAPS.
    assign rd_addr = wp - cnt;

    // ---------------- FSM: state register ----------------
    // NOTE: every clocked process uses non-blocking assignments so all
    // registers update together from the values present before the edge.
    always_ff @(posedge clk) begin
        if (rst) state <= CLEAR;
        else     state <= state_next;
    end

    // ---------------- FSM: next state ----------------
    // NOTE: combinational outputs get a default first so no path leaves them
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            CLEAR:   if (cnt == LAST_IDX) state_next = IDLE;
            IDLE:    if (in_valid)        state_next = MAC;
            MAC:     if (cnt == LAST_IDX) state_next = DRAIN;
            DRAIN:   state_next = OUT;
            OUT:     state_next = IDLE;
            default: state_next = CLEAR;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready = (state == IDLE) && !rst;
    end

    // ---------------- Output arithmetic ----------------
    // DRAIN folds the last product in combinationally so the result can be
    // registered on the DRAIN->OUT edge and strobed during OUT.
    always_comb begin
        acc_final = acc + ACC_WIDTH'(prod);
        rounded   = (ACC_WIDTH+1)'(acc_final) + ROUND_ADD;
        shifted   = rounded >>> SHIFT;
        if (shifted > SAT_MAX)      sat_value = SAT_MAX[WIDTH-1:0];
        else if (shifted < SAT_MIN) sat_value = SAT_MIN[WIDTH-1:0];
        else                        sat_value = shifted[WIDTH-1:0];
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            wp         <= '0;
            acc        <= '0;
            prod       <= '0;
            prod_valid <= 1'b0;
            out_data   <= '0;
            out_valid  <= 1'b0;
        end else begin
            out_valid  <= 1'b0;
            prod_valid <= 1'b0;
            case (state)
                CLEAR: cnt <= cnt + 1'b1;       // wraps to 0 on leaving CLEAR
                IDLE: begin
                    if (in_valid) begin
                        acc <= '0;
                        cnt <= '0;
                    end
                end
                MAC: begin
                    prod       <= PROD_W'(coef_mem[cnt]) * PROD_W'(delay_mem[rd_addr]);
                    prod_valid <= 1'b1;
                    if (prod_valid) acc <= acc + ACC_WIDTH'(prod);
                    cnt <= cnt + 1'b1;          // wraps to 0 after the last tap
                end
                DRAIN: begin
                    acc       <= acc_final;
                    out_data  <= sat_value;
                    out_valid <= 1'b1;
                end
                OUT: wp <= wp + 1'b1;
                default: ;
            endcase
        end
    end

    // ---------------- Storage ----------------
    // NOTE: the arrays have no reset branch; CLEAR zeroes them one entry per
    // cycle, which keeps them mappable onto RAM.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                delay_mem[cnt] <= '0;
                coef_mem[cnt]  <= '0;
            end else if (state == IDLE) begin
                if (coef_we)  coef_mem[coef_addr] <= coef_data;
                if (in_valid) delay_mem[wp]       <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_fir_filter_mac.sv
// -----------------------------------------------------------------------------
// tb_fir_filter_mac
//   Directed bench for fir_filter_mac with WIDTH=18, COEF_WIDTH=18, TAPS=8,
//   SHIFT=8. Inputs change on the falling edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_fir_filter_mac;

    localparam int WIDTH = 18;
    localparam int COEF_WIDTH = 18;
    localparam int TAPS = 8;
    localparam int SHIFT = 8;
    localparam int LAT = TAPS + 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [WIDTH-1:0]        in_data;
    logic                    in_valid;
    logic                    in_ready;
    logic                    coef_we;
    logic [$clog2(TAPS)-1:0] coef_addr;
    logic [COEF_WIDTH-1:0]   coef_data;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;

    int vectors = 0;
    int miscompares = 0;

    fir_filter_mac #(
        .WIDTH(WIDTH), .COEF_WIDTH(COEF_WIDTH), .TAPS(TAPS), .SHIFT(SHIFT)
    ) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .out_data(out_data), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int observed, input int expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Asserts rst for 'hold' cycles, then counts cycles with in_ready low.
    task automatic pulse_reset(input int hold, output int lows, output int saw_valid);
        rst = 1'b1;
        repeat (hold) @(negedge clk);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'($signed(out_data)), 0);
        rst = 1'b0;
        lows = 0;
        saw_valid = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) saw_valid = 1;
            if (in_ready) break;
            lows++;
            @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50; i++) begin
            if (in_ready) break;
            @(negedge clk);
        end
        if (!in_ready) check("wait_idle", int'(in_ready), 1);
    endtask

    task automatic write_coef(input int addr, input int data);
        wait_idle();
        coef_we   = 1'b1;
        coef_addr = ($clog2(TAPS))'(addr);
        coef_data = COEF_WIDTH'(data);
        @(negedge clk);
        coef_we   = 1'b0;
    endtask

    // Called on the negedge of cycle 1 after a handshake.
    task automatic wait_out(output int lat, output int y);
        lat = -1;
        y = 0;
        for (int j = 1; j <= 30; j++) begin
            if (out_valid) begin
                lat = j;
                y = int'($signed(out_data));
                break;
            end
            @(negedge clk);
        end
        if (lat >= 0) begin
            @(negedge clk);
            check("strobe_len", int'(out_valid), 0);
        end
    endtask

    task automatic send_sample(input int x, output int lat, output int y);
        wait_idle();
        in_valid = 1'b1;
        in_data  = WIDTH'(x);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 18'h2AAAA;           // must not be picked up later
        wait_out(lat, y);
    endtask

    initial begin
        int lows, saw, lat, y, lat2, y2, hs_next;
        int imp_exp [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 0};

        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        coef_we = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        @(negedge clk);

        // ---- Power-up reset and clear ----
        pulse_reset(2, lows, saw);
        check("clear_len_initial", lows, TAPS);

        // ---- Preload garbage, then reset: everything must be zeroed ----
        for (int k = 0; k < TAPS; k++) write_coef(k, 1000 + 37 * k);
        send_sample(777, lat, y);
        send_sample(-555, lat, y);
        @(negedge clk);
        pulse_reset(1, lows, saw);
        check("clear_len", lows, TAPS);
        write_coef(0, 256);
        send_sample(1234, lat, y);
        check("clear_first_y", y, 1234);
        check("clear_first_lat", lat, LAT);

        // ---- Impulse response ----
        @(negedge clk);
        pulse_reset(1, lows, saw);
        for (int k = 0; k < TAPS; k++) write_coef(k, 256 * k);
        for (int n = 0; n < 10; n++) begin
            send_sample((n == 0) ? 1 : 0, lat, y);
            check($sformatf("impulse_y%0d", n), y, imp_exp[n]);
            check($sformatf("impulse_lat%0d", n), lat, LAT);
        end

        // ---- Rounding (half up) ----
        @(negedge clk);
        pulse_reset(1, lows, saw);
        write_coef(0, 128);
        send_sample(1, lat, y);
        check("round_p1", y, 1);
        send_sample(-1, lat, y);
        check("round_m1", y, 0);
        send_sample(3, lat, y);
        check("round_p3", y, 2);
        repeat (3) @(negedge clk);
        check("out_hold", int'($signed(out_data)), 2);

        // ---- Saturation ----
        write_coef(0, 131071);
        send_sample(131071, lat, y);
        check("sat_pos", y, 131071);
        send_sample(-131072, lat, y);
        check("sat_neg", y, -131072);
        send_sample(-256, lat, y);
        check("near_neg", y, -131071);
        send_sample(256, lat, y);
        check("near_pos", y, 131071);

        // ---- Busy rules: coef write during MAC ignored, backpressure ----
        write_coef(0, 256);
        wait_idle();
        in_valid = 1'b1;
        in_data  = WIDTH'(100);
        lat = -1;
        y = 0;
        hs_next = -1;
        for (int j = 1; j <= 30; j++) begin
            @(negedge clk);
            in_data   = WIDTH'(200);
            coef_we   = (j == 3);
            coef_addr = '0;
            coef_data = COEF_WIDTH'(5000);
            if (out_valid && lat < 0) begin
                lat = j;
                y = int'($signed(out_data));
            end
            if (in_ready) begin
                hs_next = j;
                break;
            end
        end
        coef_we = 1'b0;
        check("busy_lat", lat, LAT);
        check("busy_y", y, 100);
        check("busy_next_accept", hs_next, TAPS + 3);
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(lat2, y2);
        check("busy_second_lat", lat2, LAT);
        check("busy_coef_ignored", y2, 200);

        // ---- Reset in the middle of MAC ----
        wait_idle();
        in_valid = 1'b1;
        in_data  = WIDTH'(500);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);      // now in cycle 4 after the handshake
        pulse_reset(1, lows, saw);
        check("midmac_clear_len", lows, TAPS);
        check("midmac_no_valid", saw, 0);
        check("midmac_out_data", int'($signed(out_data)), 0);
        write_coef(0, 256);
        write_coef(1, 256);
        send_sample(300, lat, y);
        check("midmac_next_y", y, 300);
        check("midmac_next_lat", lat, LAT);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
